// File: rtl/secuenciador_barrido.sv
// Self-test sequencer: sweeps abcd through 0..15, holds each value DWELL clocks,
// and stores the sampled block outputs in a 16-entry table.
// Optional golden-table comparator enabled by defining SECUENCIADOR_CMP_EN.
module secuenciador_barrido #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned N_OUT = 3
`ifdef SECUENCIADOR_CMP_EN
    ,
    parameter logic [16*N_OUT-1:0] ESPERADO = '0
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [3:0]       abcd,
    input  logic [N_OUT-1:0] res_in,
    output logic             busy,
    output logic             done,
    input  logic [3:0]       rd_addr,
    output logic [N_OUT-1:0] rd_data
`ifdef SECUENCIADOR_CMP_EN
    ,
    output logic             error,
    output logic [3:0]       err_addr
`endif
);

    typedef enum logic [1:0] {IDLE, APLICAR, FIN} estado_t;

    localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

    estado_t          estado;
    logic [7:0]       cnt;
    logic [N_OUT-1:0] mem [16];
    logic             muestra_c;
    logic             arranque_c;

    // A sample is taken on the last dwell cycle unless abort wins that cycle
    assign muestra_c  = (estado == APLICAR) && !abort && (cnt == CNT_LAST);
    assign arranque_c = (estado == IDLE) && start && !abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            estado  <= IDLE;
            abcd    <= 4'd0;
            cnt     <= 8'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_data <= '0;
            for (int i = 0; i < 16; i++) begin
                mem[i] <= '0;
            end
        end else begin
            rd_data <= mem[rd_addr];
            done    <= 1'b0;
            if (muestra_c) begin
                mem[abcd] <= res_in;
            end
            case (estado)
                IDLE: begin
                    if (arranque_c) begin
                        estado <= APLICAR;
                        abcd   <= 4'd0;
                        cnt    <= 8'd0;
                        busy   <= 1'b1;
                    end
                end
                APLICAR: begin
                    if (abort) begin
                        estado <= IDLE;
                        busy   <= 1'b0;
                        abcd   <= 4'd0;
                        cnt    <= 8'd0;
                    end else if (cnt == CNT_LAST) begin
                        if (abcd == 4'd15) begin
                            estado <= FIN;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            abcd <= abcd + 4'd1;
                            cnt  <= 8'd0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                FIN: begin
                    estado <= IDLE;
                end
                default: begin
                    estado <= IDLE;
                end
            endcase
        end
    end

`ifdef SECUENCIADOR_CMP_EN
    logic [N_OUT-1:0] esperado_c;

    assign esperado_c = ESPERADO[int'(abcd) * int'(N_OUT) +: N_OUT];

    // Sticky first-mismatch capture, rearmed by a start that begins a sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            error    <= 1'b0;
            err_addr <= 4'd0;
        end else if (arranque_c) begin
            error <= 1'b0;
        end else if (muestra_c && !error && (res_in != esperado_c)) begin
            error    <= 1'b1;
            err_addr <= abcd;
        end
    end
`endif

endmodule

// File: tb/tb_secuenciador_barrido.sv
// Bench for secuenciador_barrido: two instances (DWELL=2 and DWELL=1) checked every
// cycle against a time-index reference model, plus directed literal checks.
module tb_secuenciador_barrido;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst     = 1'b1;
    logic       start   = 1'b0;
    logic       abort   = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic [2:0] mask    = 3'd0;

    logic [3:0] abcd0, abcd1;
    logic       busy0, busy1, done0, done1;
    logic [2:0] rd0, rd1, res0, res1;

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    // Behaviour of the combinational block: {a&b, c|d, a^b^c^d}
    function automatic logic [2:0] f(input logic [3:0] x);
        return {x[3] & x[2], x[1] | x[0], ^x};
    endfunction

    assign res0 = f(abcd0) ^ mask;
    assign res1 = f(abcd1) ^ mask;

`ifdef SECUENCIADOR_CMP_EN
    function automatic logic [47:0] golden();
        logic [47:0] g;
        g = '0;
        for (int i = 0; i < 16; i++) g[i*3 +: 3] = f(4'(i));
        g[27 +: 3] = g[27 +: 3] ^ 3'b001;
        return g;
    endfunction
    localparam logic [47:0] ESP = golden();
    logic       err0, err1;
    logic [3:0] ea0, ea1;
`endif

    secuenciador_barrido #(
        .DWELL(2), .N_OUT(3)
`ifdef SECUENCIADOR_CMP_EN
        , .ESPERADO(ESP)
`endif
    ) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .abcd(abcd0),
        .res_in(res0), .busy(busy0), .done(done0), .rd_addr(rd_addr), .rd_data(rd0)
`ifdef SECUENCIADOR_CMP_EN
        , .error(err0), .err_addr(ea0)
`endif
    );

    secuenciador_barrido #(
        .DWELL(1), .N_OUT(3)
`ifdef SECUENCIADOR_CMP_EN
        , .ESPERADO(ESP)
`endif
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .abcd(abcd1),
        .res_in(res1), .busy(busy1), .done(done1), .rd_addr(rd_addr), .rd_data(rd1)
`ifdef SECUENCIADOR_CMP_EN
        , .error(err1), .err_addr(ea1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a sweep is an elapsed-time index t in 0..16*D-1
    int         dw [2] = '{2, 1};
    int         ph [2];
    int         t  [2];
    logic [3:0] m_abcd [2];
    logic       m_busy [2];
    logic       m_done [2];
    logic [2:0] m_rd   [2];
    logic [2:0] m_mem  [2][16];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                ph[i] <= 0;
                t[i] <= 0;
                m_abcd[i] <= 4'd0;
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
                m_rd[i] <= 3'd0;
                for (int k = 0; k < 16; k++) m_mem[i][k] <= 3'd0;
            end else begin
                m_rd[i] <= m_mem[i][rd_addr];
                m_done[i] <= 1'b0;
                if (ph[i] == 0) begin
                    if (start && !abort) begin
                        ph[i] <= 1;
                        t[i] <= 0;
                        m_abcd[i] <= 4'd0;
                        m_busy[i] <= 1'b1;
                    end
                end else if (ph[i] == 1) begin
                    if (abort) begin
                        ph[i] <= 0;
                        m_busy[i] <= 1'b0;
                        m_abcd[i] <= 4'd0;
                    end else begin
                        if (t[i] % dw[i] == dw[i] - 1)
                            m_mem[i][4'(t[i] / dw[i])] <= f(4'(t[i] / dw[i])) ^ mask;
                        if (t[i] == 16 * dw[i] - 1) begin
                            ph[i] <= 2;
                            m_done[i] <= 1'b1;
                            m_busy[i] <= 1'b0;
                        end else begin
                            t[i] <= t[i] + 1;
                            m_abcd[i] <= 4'((t[i] + 1) / dw[i]);
                        end
                    end
                end else begin
                    ph[i] <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("abcd0", 32'(abcd0), 32'(m_abcd[0]));
            chk("busy0", 32'(busy0), 32'(m_busy[0]));
            chk("done0", 32'(done0), 32'(m_done[0]));
            chk("rd0",   32'(rd0),   32'(m_rd[0]));
            chk("abcd1", 32'(abcd1), 32'(m_abcd[1]));
            chk("busy1", 32'(busy1), 32'(m_busy[1]));
            chk("done1", 32'(done1), 32'(m_done[1]));
            chk("rd1",   32'(rd1),   32'(m_rd[1]));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [3:0] a, input logic [2:0] e);
        rd_addr = a;
        tick(1);
        chk("readback0", 32'(rd0), 32'(e));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        int nb0, nb1, nd0, nd1;
        tick(2);
        chk("rst_abcd", 32'(abcd0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_rd",   32'(rd0),   32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Full sweep, both dwell values
        pulse_start();
        nb0 = 0; nb1 = 0; nd0 = 0; nd1 = 0;
        for (int c = 0; c < 60; c++) begin
            nb0 += int'(busy0); nb1 += int'(busy1);
            nd0 += int'(done0); nd1 += int'(done1);
            tick(1);
        end
        chk("busy_len_d2", 32'(nb0), 32'd32);
        chk("busy_len_d1", 32'(nb1), 32'd16);
        chk("done_cnt_d2", 32'(nd0), 32'd1);
        chk("done_cnt_d1", 32'(nd1), 32'd1);
        chk("abcd_hold15", 32'(abcd0), 32'd15);
        rd(4'd5, 3'b010);
        rd(4'd15, 3'b110);
        rd(4'd0, 3'b000);
`ifdef SECUENCIADOR_CMP_EN
        chk("err_set", 32'(err0), 32'd1);
        chk("err_addr", 32'(ea0), 32'd9);
`endif

        // Reset three cycles into a sweep clears everything
        pulse_start();
`ifdef SECUENCIADOR_CMP_EN
        chk("err_clr_start", 32'(err0), 32'd0);
`endif
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_abcd", 32'(abcd0), 32'd0);
        chk("midrst_busy", 32'(busy0), 32'd0);
        chk("midrst_done", 32'(done0), 32'd0);
        for (int a = 0; a < 16; a++) rd(4'(a), 3'd0);

        // Abort at abcd=6 keeps earlier entries, leaves later ones untouched
        pulse_start();
        tick(40);
`ifdef SECUENCIADOR_CMP_EN
        chk("err_reset_again", 32'(err0), 32'd1);
        chk("err_addr_again", 32'(ea0), 32'd9);
`endif
        mask = 3'd7;
        pulse_start();
        for (int c = 0; c < 40 && abcd0 != 4'd6; c++) begin
            rd_addr = abcd0;
            tick(1);
        end
        chk("reach_abcd6", 32'(abcd0), 32'd6);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_abcd", 32'(abcd0), 32'd0);
        nd0 = 0; nd1 = 0;
        for (int c = 0; c < 40; c++) begin
            nd0 += int'(done0); nd1 += int'(done1);
            tick(1);
        end
        chk("abort_nodone0", 32'(nd0), 32'd0);
        chk("abort_nodone1", 32'(nd1), 32'd0);
        for (int a = 0; a < 16; a++) rd(4'(a), (a < 6) ? (f(4'(a)) ^ 3'd7) : f(4'(a)));
        mask = 3'd0;

        // Restart pulse mid-sweep is ignored
        nb0 = 0; nd0 = 0;
        start = 1'b1;
        for (int c = 0; c < 60; c++) begin
            tick(1);
            start = (c == 5);
            nb0 += int'(busy0); nd0 += int'(done0);
        end
        chk("restart_len", 32'(nb0), 32'd32);
        chk("restart_done", 32'(nd0), 32'd1);

        // Held start: one idle cycle between done and the next busy
        start = 1'b1;
        for (int c = 0; c < 80 && !done0; c++) tick(1);
        chk("held_done", 32'(done0), 32'd1);
        tick(1);
        chk("held_gap_busy", 32'(busy0), 32'd0);
        chk("held_gap_done", 32'(done0), 32'd0);
        tick(1);
        chk("held_rebusy", 32'(busy0), 32'd1);
        start = 1'b0;
        tick(40);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            start   = ($urandom % 6) == 0;
            abort   = ($urandom % 50) == 0;
            rst     = ($urandom % 400) == 0;
            rd_addr = 4'($urandom);
            mask    = 3'($urandom);
            tick(1);
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
